hazard_control_unit: RTL and testbench

- Sequences the ID/EX pipeline register and the front end: load-use bubbles, taken-branch flushes and multi-cycle mul/div stalls.
- Drives flush_ID_EX, which inserts a bubble (ALUOp=4'b1111, all control bits 0).
- Drives PCWrite and IF_ID_Write for the fetch stage.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_control_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control unit: sequences the ID/EX pipeline register and the fetch
// stage through load-use bubbles, taken-branch flushes and multi-cycle
// mul/div stalls, and keeps saturating stall/flush event counters.
module hazard_control_unit #(
    parameter int unsigned MULDIV_LAT     = 4,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic             branch_taken_EX,
    input  logic             muldiv_start_EX,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             stall_active,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        BR_FLUSH = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    // Down-counter preloads: the cycle that enters the state is not counted,
    // so each state lasts preload+1 cycles after the triggering cycle.
    localparam logic [3:0] MD_INIT = 4'(MULDIV_LAT - 2);
    localparam logic [3:0] BR_INIT = (BRANCH_PENALTY > 1) ? 4'(BRANCH_PENALTY - 2) : 4'd0;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stallCount_q, flushCount_q;
    logic             loadUse;

    assign loadUse = EX_MemRead && (EX_Rt != 5'd0) &&
                     ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    // Next-state and Mealy control outputs; reset forces both flushes and freezes fetch
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        stall_active = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken_EX) begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_d = BR_FLUSH;
                        cnt_d   = BR_INIT;
                    end
                end else if (muldiv_start_EX) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    flush_ID_EX  = 1'b1;
                    stall_active = 1'b1;
                    state_d      = MD_BUSY;
                    cnt_d        = MD_INIT;
                end else if (loadUse) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    flush_ID_EX  = 1'b1;
                    stall_active = 1'b1;
                end
            end
            MD_BUSY: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                flush_ID_EX  = 1'b1;
                stall_active = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BR_FLUSH: begin
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
        if (!reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            stall_active = 1'b0;
        end
    end

    // State and down-counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating performance counters: they stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCount_q <= '0;
            flushCount_q <= '0;
        end else begin
            if (stall_active && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + 1'b1;
            end
            if (flush_IF_ID && (flushCount_q != '1)) begin
                flushCount_q <= flushCount_q + 1'b1;
            end
        end
    end

    assign state_out   = state_q;
    assign stall_count = stallCount_q;
    assign flush_count = flushCount_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed testbench for hazard_control_unit with a small expected-value
// scoreboard. Counters are narrowed so saturation is reachable quickly.
module tb_hazard_control_unit;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_Rs, ID_Rt, EX_Rt;
    logic             ID_UsesRt, EX_MemRead, branch_taken_EX, muldiv_start_EX;
    logic             PCWrite, IF_ID_Write, flush_IF_ID, flush_ID_EX, stall_active;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct {
        string            tag;
        logic             pcw, ifw, fif, fex, stall;
        logic [1:0]       state;
        logic [CNT_W-1:0] stallCnt, flushCnt;
    } exp_t;

    exp_t             scoreboard[$];
    int               compared   = 0;
    int               mismatched = 0;
    logic [CNT_W-1:0] expStall   = '0;
    logic [CNT_W-1:0] expFlush   = '0;

    hazard_control_unit #(
        .MULDIV_LAT(4),
        .BRANCH_PENALTY(3),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ID_Rs(ID_Rs),
        .ID_Rt(ID_Rt),
        .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead),
        .EX_Rt(EX_Rt),
        .branch_taken_EX(branch_taken_EX),
        .muldiv_start_EX(muldiv_start_EX),
        .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .flush_IF_ID(flush_IF_ID),
        .flush_ID_EX(flush_ID_EX),
        .stall_active(stall_active),
        .state_out(state_out),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a visible failure
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string tag, input string field, input logic [15:0] got, input logic [15:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s: got %0h expected %0h", tag, field, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = scoreboard.pop_front();
        cmp(e.tag, "PCWrite",      16'(PCWrite),      16'(e.pcw));
        cmp(e.tag, "IF_ID_Write",  16'(IF_ID_Write),  16'(e.ifw));
        cmp(e.tag, "flush_IF_ID",  16'(flush_IF_ID),  16'(e.fif));
        cmp(e.tag, "flush_ID_EX",  16'(flush_ID_EX),  16'(e.fex));
        cmp(e.tag, "stall_active", 16'(stall_active), 16'(e.stall));
        cmp(e.tag, "state_out",    16'(state_out),    16'(e.state));
        cmp(e.tag, "stall_count",  16'(stall_count),  16'(e.stallCnt));
        cmp(e.tag, "flush_count",  16'(flush_count),  16'(e.flushCnt));
    endtask

    // Drives one cycle of inputs, queues what the unit should show in that
    // cycle, checks at the falling edge, then advances past the rising edge.
    task automatic applyStimulus(
        input string tag, input logic rst,
        input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
        input logic memRead, input logic [4:0] exRt,
        input logic br, input logic md,
        input logic pcw, input logic ifw, input logic fif, input logic fex,
        input logic stall, input logic [1:0] st);
        exp_t e;
        reset           = rst;
        ID_Rs           = rs;
        ID_Rt           = rt;
        ID_UsesRt       = usesRt;
        EX_MemRead      = memRead;
        EX_Rt           = exRt;
        branch_taken_EX = br;
        muldiv_start_EX = md;
        if (!rst) begin
            expStall = '0;
            expFlush = '0;
        end
        e.tag = tag; e.pcw = pcw; e.ifw = ifw; e.fif = fif; e.fex = fex;
        e.stall = stall; e.state = st; e.stallCnt = expStall; e.flushCnt = expFlush;
        scoreboard.push_back(e);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        if (rst) begin
            if (stall && expStall != CNT_MAX) expStall = expStall + 1'b1;
            if (fif && expFlush != CNT_MAX) expFlush = expFlush + 1'b1;
        end
        #1;
    endtask

    initial begin
        // Reset held for three cycles
        for (int i = 0; i < 3; i++)
            applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("run0",      1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Load-use on Rs, then with Rt=0 (never a hazard)
        applyStimulus("luRs",      1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("luRsAfter", 1, 5, 0, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("luZero",    1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // Rt match only counts when the instruction reads Rt
        applyStimulus("rtNoUse",   1, 0, 7, 0, 1, 7, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("rtUse",     1, 0, 7, 1, 1, 7, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("rtAfter",   1, 0, 7, 1, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0);

        // Mul/div: four frozen cycles, branch mid-busy ignored
        applyStimulus("mdStart",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        applyStimulus("mdBusy1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus("mdBusyBr",  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus("mdBusy3",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus("mdDone",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Branch wins over load-use and mul/div; BR_FLUSH ignores inputs
        applyStimulus("brAll",     1, 5, 0, 0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0);
        applyStimulus("brFlush1",  1, 5, 0, 0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 2);
        applyStimulus("brFlush2",  1, 5, 0, 0, 1, 5, 0, 1, 1, 1, 1, 1, 0, 2);
        applyStimulus("brDone",    1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Reset asserted mid-MD_BUSY takes effect without a clock edge
        applyStimulus("mdStart2",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        applyStimulus("midReset",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("midReset2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus("postReset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Drive stall_count past its maximum, then check it holds
        for (int i = 0; i < 4; i++) begin
            applyStimulus("satMd0", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
            applyStimulus("satMd1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
            applyStimulus("satMd2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
            applyStimulus("satMd3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        end
        applyStimulus("satIdle",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("satLu",     1, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus("satHold",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Drive flush_count past its maximum with repeated branches
        for (int i = 0; i < 6; i++) begin
            applyStimulus("satBr0", 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0);
            applyStimulus("satBr1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2);
            applyStimulus("satBr2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2);
        end
        applyStimulus("satFlHold", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        if (scoreboard.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got %0d leftover entries, expected 0", scoreboard.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
